// File: rtl/bitcount_unit.sv
// Multi-cycle Zbb CPOP/CLZ/CTZ unit: scans CHUNK_WIDTH bits per clock, result NUM_CHUNKS+1 cycles after accept.
// Holds the result in DONE until out_ready; BITCNT_ZERO_BYPASS_EN lets zero operands finish one cycle after accept.
module bitcount_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] OP_CPOP = 2'b00;
    localparam logic [1:0] OP_CLZ  = 2'b01;
    localparam logic [1:0] OP_CTZ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_params
        $error("bitcount_unit: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    function automatic logic [CNT_W-1:0] pop_cnt(input logic [CHUNK_WIDTH-1:0] c);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            n = n + CNT_W'(c[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] lead_zeros(input logic [CHUNK_WIDTH-1:0] c);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (c[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] trail_zeros(input logic [CHUNK_WIDTH-1:0] c);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (c[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

`ifdef BITCNT_ZERO_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] zero_result(input logic [1:0] op);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        if (op == OP_CLZ || op == OP_CTZ) begin
            r = DATA_WIDTH'(DATA_WIDTH);
        end
        return r;
    endfunction
`endif

    state_t                state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            op_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  found_q;
    logic                  found_d;
    logic [IDX_W-1:0]      sel_idx;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic                  last_chunk;
    logic [DATA_WIDTH-1:0] result_d;

    // CLZ walks chunks from the MSB end; CPOP and CTZ walk from the LSB end.
    always_comb begin
        sel_idx    = (op_q == OP_CLZ) ? (IDX_W'(NUM_CHUNKS - 1) - idx_q) : idx_q;
        chunk      = data_q[sel_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
        last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
        found_d    = found_q | (|chunk);
        count_d    = count_q;
        case (op_q)
            OP_CPOP: count_d = count_q + pop_cnt(chunk);
            OP_CLZ:  if (!found_q) count_d = count_q + lead_zeros(chunk);
            OP_CTZ:  if (!found_q) count_d = count_q + trail_zeros(chunk);
            default: count_d = '0;
        endcase
        result_d = {{(DATA_WIDTH - CNT_W){1'b0}}, count_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            data_q      <= '0;
            op_q        <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        op_q       <= in_op;
                        count_q    <= '0;
                        idx_q      <= '0;
                        found_q    <= 1'b0;
                        in_ready_q <= 1'b0;
`ifdef BITCNT_ZERO_BYPASS_EN
                        if (in_data == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= zero_result(in_op);
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    count_q <= count_d;
                    found_q <= found_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= result_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_bitcount_unit.sv
// Bench for bitcount_unit at 32/8 and 64/16 with a queue-based scoreboard and latency checks.
module tb_bitcount_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_op;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [63:0] w_in_data, w_out_data;
    logic [1:0]  w_in_op;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint sb_q[$];
    longint w_q[$];
    longint mon_exp;
    longint w_mon_exp;

    bitcount_unit #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    bitcount_unit #(.DATA_WIDTH(64), .CHUNK_WIDTH(16)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit-serial reference, independent of the chunked datapath.
    function automatic longint ref_cnt(input logic [63:0] d, input logic [1:0] op, input int w);
        longint n;
        n = 0;
        case (op)
            2'b00: for (int i = 0; i < w; i++) n += d[i];
            2'b01: for (int i = w - 1; i >= 0; i--) begin
                       if (d[i]) break;
                       n++;
                   end
            2'b10: for (int i = 0; i < w; i++) begin
                       if (d[i]) break;
                       n++;
                   end
            default: n = 0;
        endcase
        return n;
    endfunction

    function automatic int exp_lat(input logic [63:0] d);
`ifdef BITCNT_ZERO_BYPASS_EN
        return (d == 64'd0) ? 1 : 5;
`else
        return 5;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("out_data", longint'(out_data), mon_exp);
            end
        end
        if (!rst && w_out_valid && w_out_ready) begin
            if (w_q.size() == 0) begin
                check("w_unexpected_out", 1, 0);
            end else begin
                w_mon_exp = w_q.pop_front();
                check("w_out_data", longint'(w_out_data), w_mon_exp);
            end
        end
    end

    task automatic run_op(input logic [31:0] d, input logic [1:0] op, input int hold);
        int     n;
        longint exp_v;
        exp_v = ref_cnt({32'd0, d}, op, 32);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = (hold == 0);
        in_data  = d;
        in_op    = op;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready", in_ready, 1);
        sb_q.push_back(exp_v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("latency", n, exp_lat({32'd0, d}));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("bp_valid", out_valid, 1);
                check("bp_data", longint'(out_data), exp_v);
                check("bp_in_ready", in_ready, 0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("bp_release_in_ready", in_ready, 1);
            check("bp_release_valid", out_valid, 0);
        end
    endtask

    task automatic run_wide(input logic [63:0] d, input logic [1:0] op);
        int n;
        w_in_data  = d;
        w_in_op    = op;
        w_in_valid = 1'b1;
        n = 0;
        while (!w_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("w_in_ready", w_in_ready, 1);
        w_q.push_back(ref_cnt(d, op, 64));
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("w_latency", n, exp_lat(d));
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0; w_in_op = '0; w_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_w_in_ready", w_in_ready, 1);

        // Abort a transaction mid-scan; no result may appear.
        in_data = 32'h1234_5678; in_op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            check("midrst_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        run_op(32'hF0F0_1234, 2'b00, 0);
        run_op(32'hFFFF_FFFF, 2'b00, 0);
        run_op(32'h0001_8000, 2'b01, 0);
        run_op(32'h0001_8000, 2'b10, 0);
        run_op(32'h8000_0001, 2'b01, 0);
        run_op(32'h8000_0001, 2'b10, 0);
        run_op(32'h0000_0000, 2'b01, 0);
        run_op(32'h0000_0000, 2'b10, 0);
        run_op(32'h0000_0000, 2'b00, 0);
        run_op(32'h0000_0000, 2'b11, 0);
        run_op(32'hFFFF_FFFF, 2'b01, 0);
        run_op(32'hFFFF_FFFF, 2'b10, 0);
        run_op(32'hDEAD_BEEF, 2'b11, 0);
        run_op(32'h0F00_0000, 2'b01, 10);
        run_op(32'h0000_0040, 2'b10, 0);
        for (int i = 0; i < 12; i++) begin
            rd = $urandom;
            if (i % 3 == 1) rd = rd >> $urandom_range(0, 31);
            if (i % 3 == 2) rd = rd << $urandom_range(0, 31);
            run_op(rd, 2'($urandom_range(0, 3)), 0);
        end

        run_wide(64'h0000_0000_0000_0100, 2'b01);
        run_wide(64'hFFFF_FFFF_FFFF_FFFF, 2'b00);
        run_wide(64'h0000_0000_0000_0000, 2'b10);
        run_wide(64'h0010_0000_0000_0000, 2'b10);
        run_wide({$urandom, $urandom}, 2'b00);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        check("w_sb_empty", w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
